// File: rtl/load_store_unit.sv
// load_store_unit: splits byte/word CPU accesses into word bus cycles
// ports: clk/rst_n, req_* from execute, resp_* completion, mem_* decoder bus
package lsu_pkg;
  typedef struct packed {
    logic ph0;
  } clock_t;
endpackage

module load_store_unit
  import lsu_pkg::*;
(
  input  clock_t      clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_w_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_w,
  input  logic [15:0] mem_data_r
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAP,
    WR,
    RESP
  } state_t;

  state_t      state;
  logic [1:0]  phase;
  logic        op_write;
  logic        op_byte;
  logic        op_signed;
  logic        op_odd;
  logic        op_unal;
  logic [15:0] op_w;
  logic [15:0] op_wdata;
  logic [7:0]  rd0_hi;

  logic ph0;
  assign ph0 = clk.ph0;

  logic [15:0] a_w;
  logic [15:0] a_w2;
  logic        a_unal;
  logic        a_win_w;
  logic        a_win_w2;
  logic        a_err;
  logic        a_direct;

  assign a_w      = {req_addr[15:1], 1'b0};
  assign a_w2     = a_w + 16'd2;
  assign a_unal   = req_addr[0] & ~req_byte;
  assign a_win_w  = (a_w[15:12] == 4'h7);
  assign a_win_w2 = (a_w2[15:12] == 4'h7);
  assign a_err    = a_unal & (a_win_w | a_win_w2);
  // writes needing no read: aligned word, or MMIO byte
  assign a_direct = req_write & ~a_unal
                  & (~req_byte | a_win_w);

  logic        second;
  logic        more;
  logic [15:0] op_w2;

  assign second = (phase == 2'd1);
  assign more   = op_unal & ~second;
  assign op_w2  = op_w + 16'd2;

  logic [7:0]  ld_byte;
  logic [15:0] ld_data;

  assign ld_byte = op_odd ? mem_data_r[15:8]
                          : mem_data_r[7:0];

  always_comb begin
    ld_data = mem_data_r;
    if (op_byte)
      ld_data = {{8{op_signed & ld_byte[7]}},
                 ld_byte};
    else if (op_unal)
      ld_data = {mem_data_r[7:0], rd0_hi};
  end

  logic [7:0]  ins_byte;
  logic        ins_hi;
  logic [15:0] st_data;

  // split store: low data byte to W[15:8],
  // high data byte to W2[7:0]
  assign ins_byte = (op_unal & second)
                  ? op_wdata[15:8]
                  : op_wdata[7:0];
  assign ins_hi   = op_unal ? ~second : op_odd;
  assign st_data  = ins_hi
                  ? {ins_byte, mem_data_r[7:0]}
                  : {mem_data_r[15:8], ins_byte};

  assign req_ready = (state == IDLE);

  always_ff @(posedge ph0 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= 2'd0;
      op_write   <= 1'b0;
      op_byte    <= 1'b0;
      op_signed  <= 1'b0;
      op_odd     <= 1'b0;
      op_unal    <= 1'b0;
      op_w       <= 16'h0000;
      op_wdata   <= 16'h0000;
      rd0_hi     <= 8'h00;
      resp_valid <= 1'b0;
      resp_rdata <= 16'h0000;
      resp_err   <= 1'b0;
      mem_w_en   <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_data_w <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_write  <= req_write;
            op_byte   <= req_byte;
            op_signed <= req_signed;
            op_odd    <= req_addr[0];
            op_unal   <= a_unal;
            op_w      <= a_w;
            op_wdata  <= req_wdata;
            phase     <= 2'd0;
            unique case (1'b1)
              a_err: begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
              end
              a_direct: begin
                state      <= WR;
                mem_addr   <= a_w;
                mem_w_en   <= 1'b1;
                mem_data_w <= req_byte
                  ? {8'h00, req_wdata[7:0]}
                  : req_wdata;
              end
              default: begin
                state    <= RD_ISSUE;
                mem_addr <= a_w;
              end
            endcase
          end
        end
        RD_ISSUE: begin
          state <= RD_CAP;
        end
        RD_CAP: begin
          if (op_write) begin
            state      <= WR;
            mem_w_en   <= 1'b1;
            mem_data_w <= st_data;
          end else if (more) begin
            rd0_hi   <= mem_data_r[15:8];
            phase    <= 2'd1;
            mem_addr <= op_w2;
            state    <= RD_ISSUE;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= ld_data;
            mem_addr   <= 16'h0000;
            state      <= RESP;
          end
        end
        WR: begin
          mem_w_en   <= 1'b0;
          mem_data_w <= 16'h0000;
          if (more) begin
            phase    <= 2'd1;
            mem_addr <= op_w2;
            state    <= RD_ISSUE;
          end else begin
            resp_valid <= 1'b1;
            mem_addr   <= 16'h0000;
            state      <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 16'h0000;
          state      <= IDLE;
        end
        default: begin
          state    <= IDLE;
          mem_w_en <= 1'b0;
          mem_addr <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: vector table, bus sequences and random
// accesses checked against a byte-level reference model
`timescale 1ns/1ps
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        ck;
  clock_t      clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        mem_w_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_w;
  logic [15:0] mem_data_r;

  logic [15:0] mem [0:32767];

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
  } bus_t;

  bus_t bus_q[$];

  typedef struct {
    logic        w;
    logic        b;
    logic        s;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] iw;
    logic [15:0] iw2;
    logic [15:0] erd;
    logic        eerr;
    int          elat;
    int          enw;
    logic [15:0] ew;
    logic [15:0] ew2;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  assign clk.ph0    = ck;
  assign mem_data_r = mem[mem_addr[15:1]];

  load_store_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_byte   (req_byte),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_w_en   (mem_w_en),
    .mem_addr   (mem_addr),
    .mem_data_w (mem_data_w),
    .mem_data_r (mem_data_r)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // one access; bench acts as the decoder memory and
  // logs every bus cycle from cycle 1 to the response
  task automatic do_access(
    input  logic        w,
    input  logic        b,
    input  logic        s,
    input  logic [15:0] a,
    input  logic [15:0] d,
    output int          lat,
    output logic [15:0] rd,
    output logic        e,
    output int          nw);
    @(negedge ck);
    chk("ready_idle", 32'(req_ready), 32'd1);
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    req_valid  = 1'b1;
    req_write  = w;
    req_byte   = b;
    req_signed = s;
    req_addr   = a;
    req_wdata  = d;
    @(posedge ck);
    #1;
    req_valid = 1'b0;
    lat = 0;
    nw  = 0;
    rd  = 16'h0000;
    e   = 1'b0;
    bus_q.delete();
    do begin
      @(negedge ck);
      lat++;
      bus_q.push_back({mem_w_en, mem_addr,
                       mem_data_w});
      chk("addr_even", 32'(mem_addr[0]), 32'd0);
      if (lat == 1)
        chk("ready_busy", 32'(req_ready), 32'd0);
      if (mem_w_en) begin
        nw++;
        mem[mem_addr[15:1]] = mem_data_w;
      end
    end while (!resp_valid && lat < 20);
    chk("resp_seen", 32'(resp_valid), 32'd1);
    rd = resp_rdata;
    e  = resp_err;
    chk("park_addr", 32'(mem_addr), 32'd0);
    chk("park_wen", 32'(mem_w_en), 32'd0);
  endtask

  function automatic logic in_win(
    input logic [15:0] x);
    return x >= 16'h7000 && x <= 16'h7FFF;
  endfunction

  // byte-addressed view of the two touched words
  task automatic model(
    input  logic        w,
    input  logic        b,
    input  logic        s,
    input  logic [15:0] a,
    input  logic [15:0] d,
    input  logic [15:0] m0,
    input  logic [15:0] m1,
    output logic [15:0] rd,
    output logic        er,
    output int          lat,
    output int          nw,
    output logic [15:0] n0,
    output logic [15:0] n1);
    logic [7:0]  by [4];
    logic [15:0] wa;
    logic [15:0] wb;
    int          off;
    int          words;
    int          reads;
    wa = a & 16'hFFFE;
    wb = wa + 16'd2;
    by[0] = m0[7:0];
    by[1] = m0[15:8];
    by[2] = m1[7:0];
    by[3] = m1[15:8];
    off   = int'(a[0]);
    words = (!b && a[0]) ? 2 : 1;
    rd = 16'h0000;
    er = 1'b0;
    nw = 0;
    n0 = m0;
    n1 = m1;
    lat = 0;
    if (!b && a[0] && (in_win(wa) || in_win(wb))) begin
      er  = 1'b1;
      lat = 1;
    end else if (!w) begin
      if (b)
        rd = {{8{s & by[off][7]}}, by[off]};
      else
        rd = {by[off+1], by[off]};
      lat = 2 * words + 1;
    end else if (b && in_win(wa)) begin
      n0  = {8'h00, d[7:0]};
      nw  = 1;
      lat = 2;
    end else begin
      by[off] = d[7:0];
      if (!b)
        by[off+1] = d[15:8];
      n0 = {by[1], by[0]};
      n1 = {by[3], by[2]};
      reads = (!b && !a[0]) ? 0 : words;
      nw  = words;
      lat = 2 * reads + nw + 1;
    end
  endtask

  initial begin
    int          lat;
    int          nw;
    int          elat;
    int          enw;
    logic [15:0] rd;
    logic [15:0] erd;
    logic [15:0] wa;
    logic [15:0] wb;
    logic [15:0] n0;
    logic [15:0] n1;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] m0;
    logic [15:0] m1;
    logic        e;
    logic        eerr;
    logic        w;
    logic        b;
    logic        s;

    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 32768; i++)
      mem[i] = 16'h0000;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h8000, 16'h0000,
      16'hBEEF, 16'h0000, 16'hBEEF, 1'b0, 3, 0,
      16'hBEEF, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'h8001, 16'h0000,
      16'h80FF, 16'h0000, 16'hFF80, 1'b0, 3, 0,
      16'h80FF, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'h8001, 16'h0000,
      16'h80FF, 16'h0000, 16'h0080, 1'b0, 3, 0,
      16'h80FF, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h8000, 16'h0000,
      16'h80FF, 16'h0000, 16'h00FF, 1'b0, 3, 0,
      16'h80FF, 16'h0000};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'h8001, 16'h005A,
      16'h1234, 16'h0000, 16'h0000, 1'b0, 4, 1,
      16'h5A34, 16'h0000};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hA1B2,
      16'h1111, 16'h2222, 16'h0000, 1'b0, 7, 2,
      16'hB211, 16'h22A1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h7002, 16'h0041,
      16'hFFFF, 16'h0000, 16'h0000, 1'b0, 2, 1,
      16'h0041, 16'h0000};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h6FFF, 16'h0000,
      16'h1357, 16'h2468, 16'h0000, 1'b1, 1, 0,
      16'h1357, 16'h2468};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h9000, 16'hCAFE,
      16'h0000, 16'h0000, 16'h0000, 1'b0, 2, 1,
      16'hCAFE, 16'h0000};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h8003, 16'h0000,
      16'h3412, 16'h7856, 16'h5634, 1'b0, 5, 0,
      16'h3412, 16'h7856};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 16'h8006, 16'h0000,
      16'h0085, 16'h0000, 16'hFF85, 1'b0, 3, 0,
      16'h0085, 16'h0000};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h7FFF, 16'hBEEF,
      16'hAAAA, 16'h5555, 16'h0000, 1'b1, 1, 0,
      16'hAAAA, 16'h5555};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 16'hA000, 16'h0077,
      16'h1234, 16'h0000, 16'h0000, 1'b0, 4, 1,
      16'h1277, 16'h0000};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000,
      16'hAB11, 16'h22CD, 16'hCDAB, 1'b0, 5, 0,
      16'hAB11, 16'h22CD};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 16'h6FFF, 16'h1234,
      16'h0101, 16'h0202, 16'h0000, 1'b1, 1, 0,
      16'h0101, 16'h0202};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 16'h8001, 16'h0000,
      16'h7F00, 16'h0000, 16'h007F, 1'b0, 3, 0,
      16'h7F00, 16'h0000};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_byte   = 1'b0;
    req_signed = 1'b0;
    req_addr   = 16'h0000;
    req_wdata  = 16'h0000;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_wen", 32'(mem_w_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_data_w), 32'd0);
    repeat (3) @(negedge ck);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      wa = tbl[i].a & 16'hFFFE;
      wb = wa + 16'd2;
      mem[wa[15:1]] = tbl[i].iw;
      mem[wb[15:1]] = tbl[i].iw2;
      do_access(tbl[i].w, tbl[i].b, tbl[i].s,
                tbl[i].a, tbl[i].d, lat, rd, e, nw);
      chk($sformatf("t%0d_rdata", i),
          32'(rd), 32'(tbl[i].erd));
      chk($sformatf("t%0d_err", i),
          32'(e), 32'(tbl[i].eerr));
      chk($sformatf("t%0d_lat", i),
          32'(lat), 32'(tbl[i].elat));
      chk($sformatf("t%0d_nw", i),
          32'(nw), 32'(tbl[i].enw));
      chk($sformatf("t%0d_memw", i),
          32'(mem[wa[15:1]]), 32'(tbl[i].ew));
      chk($sformatf("t%0d_memw2", i),
          32'(mem[wb[15:1]]), 32'(tbl[i].ew2));
    end

    // byte store RMW bus sequence
    mem[15'h4000] = 16'h1234;
    do_access(1'b1, 1'b1, 1'b0, 16'h8001, 16'h005A,
              lat, rd, e, nw);
    chk("rmw_c1", 32'(bus_q[0]), {15'd0, 1'b0,
        16'h8000, 16'h0000});
    chk("rmw_c2_addr", 32'(bus_q[1].a), 32'h8000);
    chk("rmw_c2_wen", 32'(bus_q[1].w), 32'd0);
    chk("rmw_c3", 32'(bus_q[2]), {15'd0, 1'b1,
        16'h8000, 16'h5A34});
    chk("rmw_lat", 32'(lat), 32'd4);

    // MMIO byte store: write in cycle 1, no read
    do_access(1'b1, 1'b1, 1'b0, 16'h7003, 16'hEE41,
              lat, rd, e, nw);
    chk("mmio_c1", 32'(bus_q[0]), {15'd0, 1'b1,
        16'h7002, 16'h0041});
    chk("mmio_lat", 32'(lat), 32'd2);

    // error: no bus activity at all
    do_access(1'b0, 1'b0, 1'b0, 16'h6FFF, 16'h0000,
              lat, rd, e, nw);
    chk("err_bus_wen", 32'(bus_q[0].w), 32'd0);
    chk("err_bus_addr", 32'(bus_q[0].a), 32'd0);
    chk("err_flag", 32'(e), 32'd1);

    // split load: W in cycles 1-2, W2 in 3-4
    do_access(1'b0, 1'b0, 1'b0, 16'h8003, 16'h0000,
              lat, rd, e, nw);
    chk("split_c2", 32'(bus_q[1].a), 32'h8002);
    chk("split_c3", 32'(bus_q[2].a), 32'h8004);
    chk("split_c4", 32'(bus_q[3].a), 32'h8004);

    // reset during the second write of a split store
    mem[15'h7FFF] = 16'h1111;
    mem[15'h0000] = 16'h2222;
    @(negedge ck);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_byte  = 1'b0;
    req_addr  = 16'hFFFF;
    req_wdata = 16'hA1B2;
    @(posedge ck);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge ck);
      if (mem_w_en)
        mem[mem_addr[15:1]] = mem_data_w;
    end
    @(negedge ck);
    chk("rst6_wen", 32'(mem_w_en), 32'd1);
    chk("rst6_addr", 32'(mem_addr), 32'h0000);
    rst_n = 1'b0;
    #1;
    chk("arst_wen", 32'(mem_w_en), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    chk("arst_wdata", 32'(mem_data_w), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_resp", 32'(resp_valid), 32'd0);
    chk("arst_rdata", 32'(resp_rdata), 32'd0);
    chk("arst_err", 32'(resp_err), 32'd0);
    chk("arst_first", 32'(mem[15'h7FFF]), 32'hB211);
    chk("arst_second", 32'(mem[15'h0000]), 32'h2222);
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
    mem[15'h4000] = 16'hBEEF;
    do_access(1'b0, 1'b0, 1'b0, 16'h8000, 16'h0000,
              lat, rd, e, nw);
    chk("post_rst_rdata", 32'(rd), 32'hBEEF);
    chk("post_rst_lat", 32'(lat), 32'd3);

    // randomized accesses against the byte model
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: a = 16'h8000 + 16'($urandom_range(0, 63));
        1: a = 16'h6FF8 + 16'($urandom_range(0, 15));
        2: a = 16'h7FF8 + 16'($urandom_range(0, 15));
        3: a = 16'hFFF8 + 16'($urandom_range(0, 15));
        default: a = 16'($urandom);
      endcase
      w  = 1'($urandom);
      b  = 1'($urandom);
      s  = 1'($urandom);
      d  = 16'($urandom);
      m0 = 16'($urandom);
      m1 = 16'($urandom);
      wa = a & 16'hFFFE;
      wb = wa + 16'd2;
      mem[wa[15:1]] = m0;
      mem[wb[15:1]] = m1;
      model(w, b, s, a, d, m0, m1,
            erd, eerr, elat, enw, n0, n1);
      do_access(w, b, s, a, d, lat, rd, e, nw);
      chk($sformatf("r%0d_a%h_rdata", i, a),
          32'(rd), 32'(erd));
      chk($sformatf("r%0d_a%h_err", i, a),
          32'(e), 32'(eerr));
      chk($sformatf("r%0d_a%h_lat", i, a),
          32'(lat), 32'(elat));
      chk($sformatf("r%0d_a%h_nw", i, a),
          32'(nw), 32'(enw));
      chk($sformatf("r%0d_a%h_memw", i, a),
          32'(mem[wa[15:1]]), 32'(n0));
      chk($sformatf("r%0d_a%h_memw2", i, a),
          32'(mem[wb[15:1]]), 32'(n1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
